// File: rtl/pinwheel_ram_arb.sv
// pinwheel_ram_arb: round-robin arbiter sharing one pinwheel RAM among requesters.
// Partial-word writes become a read followed by a merge write in the next cycle.
module pinwheel_ram_arb #(
    parameter int  ports      = 3,
    parameter int  size_bytes = 512,
    localparam int addr_bits  = $clog2(size_bytes / 4),
    localparam int id_bits    = $clog2(ports)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ports-1:0]           req_valid,
    output logic [ports-1:0]           req_ready,
    input  logic [ports-1:0]           req_write,
    input  logic [ports*addr_bits-1:0] req_addr,
    input  logic [ports*32-1:0]        req_wdata,
    input  logic [ports*4-1:0]         req_mask,
    output logic                       rsp_valid,
    output logic [id_bits-1:0]         rsp_id,
    output logic [31:0]                rsp_data,
    output logic [addr_bits-1:0]       ram_raddr,
    input  logic [31:0]                ram_rdata,
    output logic [addr_bits-1:0]       ram_waddr,
    output logic [31:0]                ram_wdata,
    output logic                       ram_wren
);

    typedef enum logic {ARB, MERGE} state_t;

    state_t                r_state;
    logic [id_bits-1:0]    r_last;
    logic                  r_rsp_valid;
    logic [id_bits-1:0]    r_rsp_id;
    logic [addr_bits-1:0]  r_addr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_mask;

    logic                  w_found;
    logic [id_bits-1:0]    w_gnt;
    logic                  w_write;
    logic [addr_bits-1:0]  w_addr;
    logic [31:0]           w_wdata;
    logic [3:0]            w_mask;
    logic                  w_act;
    logic                  w_rd;
    logic                  w_fw;
    logic                  w_part;
    logic                  w_mrg;
    logic [31:0]           w_merged;

    // Rotating priority: first valid port after the last one granted.
    always_comb begin : grant
        logic [id_bits-1:0] v_idx;
        w_found = 1'b0;
        w_gnt   = '0;
        v_idx   = '0;
        for (int k = 1; k <= ports; k++) begin
            v_idx = id_bits'((int'(r_last) + k) % ports);
            if (!w_found && req_valid[v_idx]) begin
                w_found = 1'b1;
                w_gnt   = v_idx;
            end
        end
    end

    always_comb begin
        w_write = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        w_mask  = '0;
        for (int i = 0; i < ports; i++) begin
            if (w_gnt == id_bits'(i)) begin
                w_write = req_write[i];
                w_addr  = req_addr[i*addr_bits +: addr_bits];
                w_wdata = req_wdata[i*32 +: 32];
                w_mask  = req_mask[i*4 +: 4];
            end
        end
    end

    assign w_act  = rst_n && (r_state == ARB) && w_found;
    assign w_rd   = w_act && !w_write;
    assign w_fw   = w_act && w_write && (w_mask == 4'hF);
    assign w_part = w_act && w_write && (w_mask != 4'hF) && (w_mask != 4'h0);
    assign w_mrg  = rst_n && (r_state == MERGE);

    always_comb begin
        w_merged = '0;
        for (int b = 0; b < 4; b++) begin
            w_merged[b*8 +: 8] = r_mask[b] ? r_wdata[b*8 +: 8]
                                           : ram_rdata[b*8 +: 8];
        end
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < ports; i++) begin
            req_ready[i] = w_act && (w_gnt == id_bits'(i));
        end
    end

    // Every RAM-facing output is gated so reset forces it to zero.
    assign ram_raddr = (w_rd || w_part) ? w_addr : '0;
    assign ram_wren  = w_fw || w_mrg;
    assign ram_waddr = w_fw ? w_addr  : (w_mrg ? r_addr   : '0);
    assign ram_wdata = w_fw ? w_wdata : (w_mrg ? w_merged : '0);
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = rst_n ? ram_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ARB;
            r_last      <= id_bits'(ports - 1);
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_mask      <= '0;
        end else begin
            r_rsp_valid <= w_rd;
            if (w_rd) begin
                r_rsp_id <= w_gnt;
            end
            unique case (r_state)
                ARB: begin
                    if (w_act) begin
                        r_last <= w_gnt;
                    end
                    if (w_part) begin
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_mask  <= w_mask;
                        r_state <= MERGE;
                    end
                end
                MERGE: r_state <= ARB;
                default: r_state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_pinwheel_ram_arb.sv
// tb_pinwheel_ram_arb: directed scenarios plus randomized traffic
// checked against a shadow-memory scoreboard with a round-robin model.
module tb_pinwheel_ram_arb;

    localparam int P  = 3;
    localparam int SB = 512;
    localparam int AB = 7;
    localparam int IB = 2;

    logic            clk;
    logic            rst_n;
    logic [P-1:0]    req_valid;
    logic [P-1:0]    req_ready;
    logic [P-1:0]    req_write;
    logic [P*AB-1:0] req_addr;
    logic [P*32-1:0] req_wdata;
    logic [P*4-1:0]  req_mask;
    logic            rsp_valid;
    logic [IB-1:0]   rsp_id;
    logic [31:0]     rsp_data;
    logic [AB-1:0]   ram_raddr;
    logic [31:0]     ram_rdata;
    logic [AB-1:0]   ram_waddr;
    logic [31:0]     ram_wdata;
    logic            ram_wren;

    logic [31:0]     mem [0:(1<<AB)-1];
    logic            pre_we;
    logic [AB-1:0]   pre_addr;
    logic [31:0]     pre_data;

    int n_chk = 0;
    int n_fail = 0;

    pinwheel_ram_arb #(.ports(P), .size_bytes(SB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .ram_raddr(ram_raddr), .ram_rdata(ram_rdata),
        .ram_waddr(ram_waddr), .ram_wdata(ram_wdata), .ram_wren(ram_wren)
    );

    // Pinwheel RAM model with a backdoor preload port.
    always @(posedge clk) begin
        if (pre_we) mem[pre_addr] <= pre_data;
        else if (ram_wren) mem[ram_waddr] <= ram_wdata;
        ram_rdata <= mem[ram_raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL timeout: sim still running, want finished");
        $fatal(1, "timeout");
    end

    task automatic set_req(input int p, input bit w, input int a,
                           input logic [31:0] d, input logic [3:0] m);
        req_write[p]           = w;
        req_addr[p*AB +: AB]   = AB'(a);
        req_wdata[p*32 +: 32]  = d;
        req_mask[p*4 +: 4]     = m;
        req_valid[p]           = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input int a, input logic [31:0] d);
        pre_we = 1'b1; pre_addr = AB'(a); pre_data = d;
        step();
        pre_we = 1'b0;
    endtask

    task automatic do_reset;
        req_valid = '0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        set_req(0, 1, 1, 32'h1, 4'hF);
        set_req(1, 0, 2, 32'h2, 4'h0);
        set_req(2, 1, 3, 32'h3, 4'h3);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b000) begin
            n_fail++; $display("FAIL rst_ready: got %b want 000", req_ready);
        end
        n_chk++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_rsp: got v=%b id=%0d d=%h want 0 0 0",
                     rsp_valid, rsp_id, rsp_data);
        end
        n_chk++;
        if (ram_wren !== 1'b0 || ram_raddr !== '0 || ram_waddr !== '0
            || ram_wdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_ram: got we=%b ra=%0d wa=%0d wd=%h want all 0",
                     ram_wren, ram_raddr, ram_waddr, ram_wdata);
        end
        step();
        req_valid = '0;
        rst_n = 1'b1;
    endtask

    task automatic test_full_write_read;
        set_req(1, 1, 5, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b010 || ram_wren !== 1'b1 || ram_waddr !== 7'd5
            || ram_wdata !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fw_write: got rdy=%b we=%b wa=%0d wd=%h want 010 1 5 deadbeef",
                     req_ready, ram_wren, ram_waddr, ram_wdata);
        end
        step();
        set_req(1, 0, 5, 32'h0, 4'h0);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b010 || ram_wren !== 1'b0 || ram_raddr !== 7'd5
            || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fw_read: got rdy=%b we=%b ra=%0d rv=%b want 010 0 5 0",
                     req_ready, ram_wren, ram_raddr, rsp_valid);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL fw_rsp: got v=%b id=%0d d=%h want 1 1 deadbeef",
                     rsp_valid, rsp_id, rsp_data);
        end
        step();
    endtask

    task automatic test_partial_write;
        preload(7, 32'h11223344);
        set_req(0, 1, 7, 32'hAABBCCDD, 4'b0101);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b001 || ram_wren !== 1'b0 || ram_raddr !== 7'd7) begin
            n_fail++;
            $display("FAIL pw_accept: got rdy=%b we=%b ra=%0d want 001 0 7",
                     req_ready, ram_wren, ram_raddr);
        end
        step();
        set_req(0, 0, 7, 32'h0, 4'h0);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b000 || ram_wren !== 1'b1 || ram_waddr !== 7'd7
            || ram_wdata !== 32'h11BB33DD || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pw_merge: got rdy=%b we=%b wa=%0d wd=%h rv=%b want 000 1 7 11bb33dd 0",
                     req_ready, ram_wren, ram_waddr, ram_wdata, rsp_valid);
        end
        step();
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b001 || ram_wren !== 1'b0 || ram_raddr !== 7'd7) begin
            n_fail++;
            $display("FAIL pw_read: got rdy=%b we=%b ra=%0d want 001 0 7",
                     req_ready, ram_wren, ram_raddr);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h11BB33DD) begin
            n_fail++;
            $display("FAIL pw_rsp: got v=%b id=%0d d=%h want 1 0 11bb33dd",
                     rsp_valid, rsp_id, rsp_data);
        end
        step();
    endtask

    task automatic test_round_robin;
        logic [31:0] vals [P];
        logic [P-1:0] want;
        for (int p = 0; p < P; p++) begin
            vals[p] = 32'hC0DE0000 + 32'(p * 17 + 3);
            preload(20 + p, vals[p]);
        end
        do_reset();
        for (int p = 0; p < P; p++) set_req(p, 0, 20 + p, 32'h0, 4'h0);
        for (int k = 0; k < 2 * P; k++) begin
            @(negedge clk);
            want = P'(1 << (k % P));
            n_chk++;
            if (req_ready !== want) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b want %b", k, req_ready, want);
            end
            if (k > 0) begin
                n_chk++;
                if (rsp_valid !== 1'b1 || rsp_id !== IB'((k - 1) % P)
                    || rsp_data !== vals[(k - 1) % P]) begin
                    n_fail++;
                    $display("FAIL rr_rsp%0d: got v=%b id=%0d d=%h want 1 %0d %h",
                             k, rsp_valid, rsp_id, rsp_data, (k - 1) % P,
                             vals[(k - 1) % P]);
                end
            end
            step();
        end
        req_valid = '0;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_id !== IB'(P - 1) || rsp_data !== vals[P-1]) begin
            n_fail++;
            $display("FAIL rr_last: got v=%b id=%0d d=%h want 1 %0d %h",
                     rsp_valid, rsp_id, rsp_data, P - 1, vals[P-1]);
        end
        step();
    endtask

    task automatic test_mask_zero;
        preload(3, 32'h12345678);
        set_req(2, 1, 3, 32'hFFFFFFFF, 4'h0);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b100 || ram_wren !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_accept: got rdy=%b we=%b want 100 0", req_ready, ram_wren);
        end
        step();
        set_req(2, 0, 3, 32'h0, 4'h0);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b100 || ram_wren !== 1'b0 || rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL nop_read: got rdy=%b we=%b rv=%b want 100 0 0",
                     req_ready, ram_wren, rsp_valid);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL nop_rsp: got v=%b id=%0d d=%h want 1 2 12345678",
                     rsp_valid, rsp_id, rsp_data);
        end
        step();
    endtask

    task automatic test_reset_in_merge;
        preload(9, 32'h0);
        set_req(1, 1, 9, 32'hFFFFFFFF, 4'b0011);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b010) begin
            n_fail++; $display("FAIL rm_accept: got %b want 010", req_ready);
        end
        step();
        rst_n = 1'b0;
        for (int p = 0; p < P; p++) set_req(p, 0, 9, 32'h0, 4'h0);
        @(negedge clk);
        n_chk++;
        if (ram_wren !== 1'b0 || ram_waddr !== '0 || ram_wdata !== 32'h0
            || ram_raddr !== '0 || req_ready !== 3'b000 || rsp_valid !== 1'b0
            || rsp_id !== 2'd0 || rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_outputs: got we=%b wa=%0d wd=%h ra=%0d rdy=%b rv=%b id=%0d d=%h want all 0",
                     ram_wren, ram_waddr, ram_wdata, ram_raddr, req_ready,
                     rsp_valid, rsp_id, rsp_data);
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b001 || ram_raddr !== 7'd9) begin
            n_fail++;
            $display("FAIL rm_first: got rdy=%b ra=%0d want 001 9", req_ready, ram_raddr);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 32'h0) begin
            n_fail++;
            $display("FAIL rm_rsp: got v=%b id=%0d d=%h want 1 0 0",
                     rsp_valid, rsp_id, rsp_data);
        end
        step();
    endtask

    task automatic test_back_to_back;
        preload(10, 32'hAAAAAAAA);
        preload(11, 32'h55555555);
        do_reset();
        set_req(0, 1, 10, 32'h0, 4'b1000);
        set_req(1, 0, 11, 32'h0, 4'h0);
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b001) begin
            n_fail++; $display("FAIL bb_first: got %b want 001", req_ready);
        end
        step();
        req_valid[0] = 1'b0;
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b000 || rsp_valid !== 1'b0 || ram_wren !== 1'b1
            || ram_waddr !== 7'd10 || ram_wdata !== 32'h00AAAAAA) begin
            n_fail++;
            $display("FAIL bb_merge: got rdy=%b rv=%b we=%b wa=%0d wd=%h want 000 0 1 10 00aaaaaa",
                     req_ready, rsp_valid, ram_wren, ram_waddr, ram_wdata);
        end
        step();
        @(negedge clk);
        n_chk++;
        if (req_ready !== 3'b010 || ram_raddr !== 7'd11) begin
            n_fail++;
            $display("FAIL bb_second: got rdy=%b ra=%0d want 010 11", req_ready, ram_raddr);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        n_chk++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h55555555) begin
            n_fail++;
            $display("FAIL bb_rsp: got v=%b id=%0d d=%h want 1 1 55555555",
                     rsp_valid, rsp_id, rsp_data);
        end
        step();
    endtask

    task automatic test_random;
        logic [31:0]  shadow [16];
        bit           tw [P];
        int           ta [P];
        logic [31:0]  td [P];
        logic [3:0]   tm [P];
        bit           acc [P];
        int           m_last, m_addr, g, pid;
        bit           m_merge, pend, ew;
        logic [31:0]  m_data, pdata, ewd;
        int           ewa;
        logic [P-1:0] want;
        for (int a = 0; a < 16; a++) begin
            shadow[a] = $urandom;
            preload(a, shadow[a]);
        end
        do_reset();
        m_last = P - 1; m_merge = 0; pend = 0; pid = 0; pdata = 0;
        m_addr = 0; m_data = 0;
        for (int p = 0; p < P; p++) acc[p] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < P; p++) begin
                if (acc[p]) begin req_valid[p] = 1'b0; acc[p] = 0; end
                if (!req_valid[p] && $urandom_range(0, 3) != 0) begin
                    int r;
                    tw[p] = bit'($urandom_range(0, 1));
                    ta[p] = $urandom_range(0, 15);
                    td[p] = $urandom;
                    r = $urandom_range(0, 3);
                    tm[p] = (r == 0) ? 4'hF : (r == 1) ? 4'h0 : 4'($urandom);
                    set_req(p, tw[p], ta[p], td[p], tm[p]);
                end
            end
            @(negedge clk);
            n_chk++;
            if (pend) begin
                if (rsp_valid !== 1'b1 || rsp_id !== IB'(pid) || rsp_data !== pdata) begin
                    n_fail++;
                    $display("FAIL rnd_rsp c%0d: got v=%b id=%0d d=%h want 1 %0d %h",
                             c, rsp_valid, rsp_id, rsp_data, pid, pdata);
                end
            end else if (rsp_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL rnd_rsp c%0d: got v=%b want 0", c, rsp_valid);
            end
            g = -1;
            if (!m_merge) begin
                for (int k = 1; k <= P; k++) begin
                    int j;
                    j = (m_last + k) % P;
                    if (g < 0 && req_valid[j]) g = j;
                end
            end
            want = '0;
            if (g >= 0) want[g] = 1'b1;
            n_chk++;
            if (req_ready !== want) begin
                n_fail++;
                $display("FAIL rnd_grant c%0d: got %b want %b", c, req_ready, want);
            end
            ew = 0; ewa = 0; ewd = 0;
            if (m_merge) begin
                ew = 1; ewa = m_addr; ewd = m_data;
            end else if (g >= 0 && tw[g] && tm[g] == 4'hF) begin
                ew = 1; ewa = ta[g]; ewd = td[g];
            end
            n_chk++;
            if (ram_wren !== ew || (ew && (ram_waddr !== AB'(ewa) || ram_wdata !== ewd))) begin
                n_fail++;
                $display("FAIL rnd_wr c%0d: got we=%b wa=%0d wd=%h want %b %0d %h",
                         c, ram_wren, ram_waddr, ram_wdata, ew, ewa, ewd);
            end
            pend = 0;
            if (m_merge) begin
                m_merge = 0;
            end else if (g >= 0) begin
                m_last = g;
                acc[g] = 1;
                if (!tw[g]) begin
                    pend = 1; pid = g; pdata = shadow[ta[g]];
                end else if (tm[g] == 4'hF) begin
                    shadow[ta[g]] = td[g];
                end else if (tm[g] != 4'h0) begin
                    m_data = shadow[ta[g]];
                    for (int b = 0; b < 4; b++)
                        if (tm[g][b]) m_data[b*8 +: 8] = td[g][b*8 +: 8];
                    shadow[ta[g]] = m_data;
                    m_addr = ta[g];
                    m_merge = 1;
                end
            end
            step();
        end
        req_valid = '0;
        @(negedge clk);
        n_chk++;
        if (pend && (rsp_valid !== 1'b1 || rsp_id !== IB'(pid) || rsp_data !== pdata)) begin
            n_fail++;
            $display("FAIL rnd_drain: got v=%b id=%0d d=%h want 1 %0d %h",
                     rsp_valid, rsp_id, rsp_data, pid, pdata);
        end else if (!pend && rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_drain: got v=%b want 0", rsp_valid);
        end
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_write = '0; req_addr = '0;
        req_wdata = '0; req_mask = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        step();
        test_reset();
        test_full_write_read();
        test_partial_write();
        test_round_robin();
        test_mask_zero();
        test_reset_in_merge();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
